// File: rtl/cdc_event_drain_dd.sv
// Destination-domain event drain: converts handshake level transitions into queued events.
// Optional per-event timestamp FIFO enabled by defining CDC_EVENT_DRAIN_TIMESTAMP_EN.
module cdc_event_drain_dd #(
    parameter int DEPTH        = 4,
    parameter int STALL_THRESH = DEPTH - 1,
    parameter int TS_W         = 16
) (
    input  logic                         dest_clk,
    input  logic                         dest_reset_n,
    input  logic                         hs_level,
    output logic                         hs_stall,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [TS_W-1:0]              evt_ts,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         overflow,
    input  logic                         overflow_clr
);

    localparam int PW = $clog2(DEPTH + 1);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            lvl_q;
    logic            push;
    logic            pop;
    logic            full;
    logic            drop;
    logic [PW-1:0]   pending_next;

    always_ff @(posedge dest_clk or negedge dest_reset_n) begin
        if (!dest_reset_n) begin
            state_q <= PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    // PRIME spends one cycle adopting the incoming level so a stale toggle is never counted
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            PRIME: state_d = RUN;
            RUN:   push    = (hs_level != lvl_q);
            default: state_d = PRIME;
        endcase
    end

    assign evt_valid = (pending != '0);
    assign pop       = evt_valid && evt_ready;
    assign full      = (pending == PW'(DEPTH));

    // A simultaneous pop frees a slot, so a push on a full queue is only dropped without a pop
    always_comb begin
        pending_next = pending;
        drop         = 1'b0;
        if (push && !pop) begin
            if (full) begin
                drop = 1'b1;
            end else begin
                pending_next = pending + PW'(1);
            end
        end else if (pop && !push) begin
            pending_next = pending - PW'(1);
        end
    end

    always_ff @(posedge dest_clk or negedge dest_reset_n) begin
        if (!dest_reset_n) begin
            lvl_q    <= 1'b0;
            pending  <= '0;
            hs_stall <= 1'b0;
            overflow <= 1'b0;
        end else begin
            lvl_q    <= hs_level;
            pending  <= pending_next;
            hs_stall <= (pending_next >= PW'(STALL_THRESH));
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef CDC_EVENT_DRAIN_TIMESTAMP_EN
    localparam int AW = $clog2(DEPTH);

    logic [TS_W-1:0] ts_ctr;
    logic [TS_W-1:0] ts_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            accept;

    assign accept = push && (!full || pop);

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge dest_clk or negedge dest_reset_n) begin
        if (!dest_reset_n) begin
            ts_ctr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ts_mem[i] <= '0;
            end
        end else begin
            ts_ctr <= ts_ctr + TS_W'(1);
            if (accept) begin
                ts_mem[wr_ptr] <= ts_ctr;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    assign evt_ts = evt_valid ? ts_mem[rd_ptr] : '0;
`else
    assign evt_ts = '0;
`endif

endmodule

// File: tb/tb_cdc_event_drain_dd.sv
// Scoreboard bench for cdc_event_drain_dd; timestamps expected only when CDC_EVENT_DRAIN_TIMESTAMP_EN is defined.
module tb_cdc_event_drain_dd;

    localparam int DEPTH        = 4;
    localparam int STALL_THRESH = 3;
    localparam int TS_W         = 5;
    localparam int PW           = $clog2(DEPTH + 1);

    logic            dest_clk = 1'b0;
    logic            dest_reset_n;
    logic            hs_level;
    logic            hs_stall;
    logic            evt_valid;
    logic            evt_ready;
    logic [TS_W-1:0] evt_ts;
    logic [PW-1:0]   pending;
    logic            overflow;
    logic            overflow_clr;

    int vectors     = 0;
    int miscompares = 0;

    bit              m_prime;
    logic            m_lvl;
    int              m_pend;
    logic            m_ovf;
    logic [TS_W-1:0] m_ts;
    logic [TS_W-1:0] exp_q[$];
    logic            cur_lvl;

    cdc_event_drain_dd #(
        .DEPTH        (DEPTH),
        .STALL_THRESH (STALL_THRESH),
        .TS_W         (TS_W)
    ) dut (
        .dest_clk     (dest_clk),
        .dest_reset_n (dest_reset_n),
        .hs_level     (hs_level),
        .hs_stall     (hs_stall),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_ts       (evt_ts),
        .pending      (pending),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 dest_clk = ~dest_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        logic [TS_W-1:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        checkOutput("pending",   32'(pending),   32'(m_pend));
        checkOutput("evt_valid", 32'(evt_valid), 32'(m_pend != 0));
        checkOutput("hs_stall",  32'(hs_stall),  32'(m_pend >= STALL_THRESH));
        checkOutput("overflow",  32'(overflow),  32'(m_ovf));
        checkOutput("evt_ts",    32'(evt_ts),    32'(head));
    endtask

    // Called just after a falling edge: drive inputs, advance the model across the next rising edge
    task automatic applyStimulus(input logic lvl, input logic rdy, input logic clr);
        bit              push;
        bit              pop;
        bit              drop;
        logic [TS_W-1:0] head;
        logic [TS_W-1:0] ts_val;
        hs_level     = lvl;
        evt_ready    = rdy;
        overflow_clr = clr;
`ifdef CDC_EVENT_DRAIN_TIMESTAMP_EN
        ts_val = m_ts;
`else
        ts_val = '0;
`endif
        pop = (m_pend != 0) && rdy;
        if (pop) begin
            head = exp_q.pop_front();
            checkOutput("pop_ts", 32'(evt_ts), 32'(head));
        end
        push    = !m_prime && (lvl != m_lvl);
        m_prime = 1'b0;
        m_lvl   = lvl;
        drop    = 1'b0;
        if (push && !pop && m_pend == DEPTH) begin
            drop = 1'b1;
        end else if (push) begin
            exp_q.push_back(ts_val);
            if (!pop) m_pend++;
        end else if (pop) begin
            m_pend--;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_ts = m_ts + TS_W'(1);
        @(posedge dest_clk);
        @(negedge dest_clk);
        checkAll();
    endtask

    task automatic resetDut();
        #2;
        dest_reset_n = 1'b0;
        #1;
        m_prime = 1'b1;
        m_lvl   = 1'b0;
        m_pend  = 0;
        m_ovf   = 1'b0;
        m_ts    = '0;
        exp_q.delete();
        checkAll();
        @(negedge dest_clk);
        dest_reset_n = 1'b1;
    endtask

    initial begin
        hs_level     = 1'b1;
        evt_ready    = 1'b0;
        overflow_clr = 1'b0;
        dest_reset_n = 1'b1;
        cur_lvl      = 1'b1;
        resetDut();

        // Stale high level at reset release must not create an event
        for (int i = 0; i < 4; i++) applyStimulus(cur_lvl, 1'b0, 1'b0);

        // Three toggles two cycles apart reach the stall threshold
        for (int i = 0; i < 3; i++) begin
            cur_lvl = ~cur_lvl;
            applyStimulus(cur_lvl, 1'b0, 1'b0);
            applyStimulus(cur_lvl, 1'b0, 1'b0);
        end

        // Three more toggles saturate at DEPTH and flag overflow
        for (int i = 0; i < 3; i++) begin
            cur_lvl = ~cur_lvl;
            applyStimulus(cur_lvl, 1'b0, 1'b0);
        end

        // Drop and clear together: drop wins; then a lone clear
        cur_lvl = ~cur_lvl;
        applyStimulus(cur_lvl, 1'b0, 1'b1);
        applyStimulus(cur_lvl, 1'b0, 1'b1);
        applyStimulus(cur_lvl, 1'b0, 1'b0);

        // Push and pop together while full, then drain back to back
        cur_lvl = ~cur_lvl;
        applyStimulus(cur_lvl, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(cur_lvl, 1'b1, 1'b0);

        // Random traffic long enough to wrap the timestamp counter
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) cur_lvl = ~cur_lvl;
            applyStimulus(cur_lvl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
        end
        for (int i = 0; i < 6; i++) applyStimulus(cur_lvl, 1'b1, 1'b0);

        // Fill, drain one to reach three pending, then reset mid-drain
        for (int i = 0; i < 4; i++) begin
            cur_lvl = ~cur_lvl;
            applyStimulus(cur_lvl, 1'b0, 1'b0);
        end
        applyStimulus(cur_lvl, 1'b1, 1'b0);
        resetDut();

        // The level seen during PRIME differs from the reset value and is absorbed
        cur_lvl = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(cur_lvl, 1'b0, 1'b0);
        cur_lvl = ~cur_lvl;
        applyStimulus(cur_lvl, 1'b0, 1'b0);
        applyStimulus(cur_lvl, 1'b1, 1'b0);
        applyStimulus(cur_lvl, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
